// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, issues word fetches over a
// request/grant interface, tags in-order responses with their PC and buffers
// {PC, instruction} pairs in a 2-entry FIFO toward decode. A redirect from
// Stage2 reloads the PC, flushes the FIFO and discards in-flight responses.
module fetch_pc_unit #(
  parameter int unsigned    N        = 32,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REDIRECT_EN,
  input  logic [N-1:0] REDIRECT_TARGET,
  output logic         IMEM_REQ,
  output logic [N-1:0] IMEM_ADDR,
  input  logic         IMEM_GNT,
  input  logic         IMEM_RVALID,
  input  logic [N-1:0] IMEM_RDATA,
  output logic         IF_VALID,
  output logic [N-1:0] IF_PC,
  output logic [N-1:0] IF_INSTR,
  input  logic         IF_READY
);

  logic [N-1:0] pc_q, pc_d;
  logic [1:0]   outstanding_q, outstanding_d;
  logic [1:0]   kill_q, kill_d;
  // Tag queue: slot 0 is the oldest outstanding request.
  logic [N-1:0] tag0_q, tag0_d, tag1_q, tag1_d;
  // Output FIFO: slot 0 is the head presented on IF_*.
  logic [1:0]   fifo_count_q, fifo_count_d;
  logic [N-1:0] fifo_pc0_q, fifo_pc0_d, fifo_pc1_q, fifo_pc1_d;
  logic [N-1:0] fifo_instr0_q, fifo_instr0_d, fifo_instr1_q, fifo_instr1_d;

  logic         pop;
  logic         grant;
  logic         resp;
  logic         keep;
  logic [2:0]   inflight;
  logic [N-1:0] redirect_pc;
  logic [1:0]   tag_left;
  logic [1:0]   fifo_left;

  assign IF_VALID  = (fifo_count_q != 2'd0);
  assign IF_PC     = fifo_pc0_q;
  assign IF_INSTR  = fifo_instr0_q;
  assign IMEM_ADDR = pc_q;

  assign pop      = IF_VALID & IF_READY;
  // Entries already fetched or on their way count against the 2-slot FIFO.
  assign inflight = {1'b0, outstanding_q} + {1'b0, fifo_count_q} - {2'b00, pop};
  assign IMEM_REQ = (inflight < 3'd2) & ~REDIRECT_EN & ~RST;
  assign grant    = IMEM_REQ & IMEM_GNT;
  // Responses with nothing outstanding are stray and ignored.
  assign resp     = IMEM_RVALID & (outstanding_q != 2'd0);
  assign keep     = resp & (kill_q == 2'd0) & ~REDIRECT_EN;

  // Branch targets are word aligned by dropping the low bits, no trap.
  assign redirect_pc = REDIRECT_TARGET & ~(N'(3));

  // Next-state for PC, tag queue, kill accounting and output FIFO.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    kill_d        = kill_q;
    tag0_d        = tag0_q;
    tag1_d        = tag1_q;
    fifo_count_d  = fifo_count_q;
    fifo_pc0_d    = fifo_pc0_q;
    fifo_pc1_d    = fifo_pc1_q;
    fifo_instr0_d = fifo_instr0_q;
    fifo_instr1_d = fifo_instr1_q;
    tag_left      = outstanding_q - {1'b0, resp};
    fifo_left     = fifo_count_q - {1'b0, pop};

    // Tag queue: pop the oldest on a response, append the issued PC on grant.
    if (resp) begin
      tag0_d = tag1_q;
    end
    if (grant) begin
      if (tag_left == 2'd0) begin
        tag0_d = pc_q;
      end else begin
        tag1_d = pc_q;
      end
    end
    outstanding_d = tag_left + {1'b0, grant};

    // Output FIFO: shift on pop, write the first free slot on a kept response.
    if (pop) begin
      fifo_pc0_d    = fifo_pc1_q;
      fifo_instr0_d = fifo_instr1_q;
    end
    if (keep) begin
      if (fifo_left == 2'd0) begin
        fifo_pc0_d    = tag0_q;
        fifo_instr0_d = IMEM_RDATA;
      end else begin
        fifo_pc1_d    = tag0_q;
        fifo_instr1_d = IMEM_RDATA;
      end
    end
    fifo_count_d = fifo_left + {1'b0, keep};

    if (REDIRECT_EN) begin
      // Every request still outstanding after this cycle belongs to the old path.
      pc_d         = redirect_pc;
      kill_d       = tag_left;
      fifo_count_d = 2'd0;
    end else begin
      if (resp && (kill_q != 2'd0)) begin
        kill_d = kill_q - 2'd1;
      end
      if (grant) begin
        pc_d = pc_q + N'(4);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q          <= RESET_PC;
      outstanding_q <= 2'd0;
      kill_q        <= 2'd0;
      tag0_q        <= '0;
      tag1_q        <= '0;
      fifo_count_q  <= 2'd0;
      fifo_pc0_q    <= '0;
      fifo_pc1_q    <= '0;
      fifo_instr0_q <= '0;
      fifo_instr1_q <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
      tag0_q        <= tag0_d;
      tag1_q        <= tag1_d;
      fifo_count_q  <= fifo_count_d;
      fifo_pc0_q    <= fifo_pc0_d;
      fifo_pc1_q    <= fifo_pc1_d;
      fifo_instr0_q <= fifo_instr0_d;
      fifo_instr1_q <= fifo_instr1_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios, a transaction-level model
// (per-request kill flags, FIFO of {pc, instr}) compared every cycle, and a
// variable-latency in-order instruction memory.
module tb_fetch_pc_unit;

  localparam int unsigned N = 32;

  logic         CLK;
  logic         RST;
  logic         REDIRECT_EN;
  logic [N-1:0] REDIRECT_TARGET;
  logic         IMEM_REQ;
  logic [N-1:0] IMEM_ADDR;
  logic         IMEM_GNT;
  logic         IMEM_RVALID;
  logic [N-1:0] IMEM_RDATA;
  logic         IF_VALID;
  logic [N-1:0] IF_PC;
  logic [N-1:0] IF_INSTR;
  logic         IF_READY;

  fetch_pc_unit #(.N(N), .RESET_PC(32'h0000_0000)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .REDIRECT_EN     (REDIRECT_EN),
    .REDIRECT_TARGET (REDIRECT_TARGET),
    .IMEM_REQ        (IMEM_REQ),
    .IMEM_ADDR       (IMEM_ADDR),
    .IMEM_GNT        (IMEM_GNT),
    .IMEM_RVALID     (IMEM_RVALID),
    .IMEM_RDATA      (IMEM_RDATA),
    .IF_VALID        (IF_VALID),
    .IF_PC           (IF_PC),
    .IF_INSTR        (IF_INSTR),
    .IF_READY        (IF_READY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct { logic [31:0] pc; bit killed; } tag_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  tag_t        pend[$];   // model: issued requests awaiting a response
  ent_t        mf[$];     // model: output FIFO contents
  mreq_t       mq[$];     // memory: accepted requests awaiting return
  logic [31:0] acc[$];    // PCs the DUT handed downstream

  logic [31:0] m_pc;
  bit          m_req, m_pop, model_live, mem_rvalid, spur;
  int          cyc, lat;
  int          checks, fails;
  logic        req_s, vld_s;
  logic [31:0] addr_s, pc_s, instr_s;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] acc_at(int i);
    if (i < acc.size()) return acc[i];
    return 32'hFFFF_FFFF;
  endfunction

  // One clock cycle: present memory response, compare against the model,
  // then advance model and memory at the rising edge.
  task automatic cycle();
    tag_t t;
    mem_rvalid  = (mq.size() > 0) && (mq[0].due <= cyc);
    IMEM_RVALID = mem_rvalid | spur;
    IMEM_RDATA  = mem_rvalid ? (mq[0].addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    #1;
    m_pop = (mf.size() > 0) && IF_READY;
    m_req = ((pend.size() + mf.size() - (m_pop ? 1 : 0)) < 2) && !REDIRECT_EN && !RST;
    if (model_live) begin
      chk("imem_req", 32'(IMEM_REQ), 32'(m_req));
      chk("imem_addr", IMEM_ADDR, m_pc);
      chk("if_valid", 32'(IF_VALID), 32'(mf.size() > 0));
      if (mf.size() > 0) begin
        chk("if_pc", IF_PC, mf[0].pc);
        chk("if_instr", IF_INSTR, mf[0].instr);
      end
    end
    req_s   = IMEM_REQ;
    addr_s  = IMEM_ADDR;
    vld_s   = IF_VALID;
    pc_s    = IF_PC;
    instr_s = IF_INSTR;
    @(posedge CLK);
    cyc++;
    if (RST) begin
      m_pc = 32'h0;
      pend.delete();
      mf.delete();
      mq.delete();
      model_live = 1'b1;
    end else begin
      if (m_pop) void'(mf.pop_front());
      if (IMEM_RVALID && pend.size() > 0) begin
        t = pend.pop_front();
        if (!t.killed && !REDIRECT_EN) mf.push_back('{pc: t.pc, instr: IMEM_RDATA});
      end
      if (REDIRECT_EN) begin
        foreach (pend[i]) pend[i].killed = 1'b1;
        mf.delete();
        m_pc = REDIRECT_TARGET & 32'hFFFF_FFFC;
      end else if (m_req && IMEM_GNT) begin
        pend.push_back('{pc: m_pc, killed: 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (mem_rvalid) void'(mq.pop_front());
      if (req_s && IMEM_GNT) mq.push_back('{addr: addr_s, due: cyc + lat - 1});
      if (vld_s && IF_READY) acc.push_back(pc_s);
    end
    @(negedge CLK);
  endtask

  task automatic wait_pend(int n);
    int k = 0;
    while (pend.size() != n && k < 20) begin
      cycle();
      k++;
    end
    checks++;
    if (k >= 20) begin
      fails++;
      $display("FAIL wait_pend: got %0d outstanding required %0d", pend.size(), n);
    end
  endtask

  task automatic redirect(logic [31:0] target);
    REDIRECT_EN     = 1'b1;
    REDIRECT_TARGET = target;
    cycle();
    REDIRECT_EN     = 1'b0;
  endtask

  initial begin
    int k;
    int breaks;
    checks = 0; fails = 0; cyc = 0; lat = 1; spur = 1'b0; model_live = 1'b0;
    m_pc = 32'h0;
    RST = 1'b1; REDIRECT_EN = 1'b0; REDIRECT_TARGET = 32'h0;
    IMEM_GNT = 1'b1; IF_READY = 1'b1; IMEM_RVALID = 1'b0; IMEM_RDATA = 32'h0;

    // Reset state.
    cycle();
    cycle();
    chk("rst_valid", 32'(vld_s), 32'd0);
    chk("rst_pc", pc_s, 32'h0);
    chk("rst_instr", instr_s, 32'h0);
    chk("rst_req", 32'(req_s), 32'd0);

    // Stream from RESET_PC with 1-cycle memory.
    RST = 1'b0;
    acc.delete();
    cycle();
    chk("first_req", 32'(req_s), 32'd1);
    chk("first_addr", addr_s, 32'h0);
    cycle();
    chk("lat_t1_valid", 32'(vld_s), 32'd0);
    cycle();
    chk("lat_t2_valid", 32'(vld_s), 32'd1);
    chk("lat_t2_pc", pc_s, 32'h0);
    chk("lat_t2_instr", instr_s, 32'hA5A5_0000);
    repeat (6) cycle();
    chk("stream_pc0", acc_at(0), 32'h0);
    chk("stream_pc1", acc_at(1), 32'h4);
    chk("stream_pc2", acc_at(2), 32'h8);
    chk("stream_pc3", acc_at(3), 32'hC);
    chk("stream_rate", 32'(acc.size()), 32'd7);

    // Backpressure: request drops, FIFO holds, nothing lost or duplicated.
    IF_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_req_low", 32'(req_s), 32'd0);
      chk("bp_valid", 32'(vld_s), 32'd1);
    end
    IF_READY = 1'b1;
    repeat (6) cycle();
    breaks = 0;
    for (int i = 0; i + 1 < acc.size(); i++) if (acc[i+1] != acc[i] + 32'd4) breaks++;
    chk("bp_count", 32'(acc.size()), 32'd13);
    chk("bp_order_breaks", 32'(breaks), 32'd0);

    // Grant stall at 0x10, with a stray response while nothing is outstanding.
    IMEM_GNT = 1'b0;
    redirect(32'h0000_0010);
    acc.delete();
    for (int i = 0; i < 3; i++) begin
      spur = (i == 1);
      cycle();
      chk("stall_req", 32'(req_s), 32'd1);
      chk("stall_addr", addr_s, 32'h10);
    end
    spur = 1'b0;
    IMEM_GNT = 1'b1;
    cycle();
    chk("stall_grant_addr", addr_s, 32'h10);
    cycle();
    chk("stall_after_addr", addr_s, 32'h14);
    repeat (4) cycle();
    chk("stall_pc0", acc_at(0), 32'h10);
    chk("stall_pc1", acc_at(1), 32'h14);

    // Redirect with two responses pending (latency 3), unaligned target.
    lat = 3;
    wait_pend(2);
    redirect(32'h0000_0103);
    acc.delete();
    cycle();
    chk("redir_flush", 32'(vld_s), 32'd0);
    repeat (12) cycle();
    chk("redir_pc0", acc_at(0), 32'h100);
    chk("redir_pc1", acc_at(1), 32'h104);

    // Back-to-back redirects: the second one wins.
    REDIRECT_EN = 1'b1;
    REDIRECT_TARGET = 32'h0000_0300;
    cycle();
    REDIRECT_TARGET = 32'h0000_0400;
    cycle();
    REDIRECT_EN = 1'b0;
    acc.delete();
    repeat (12) cycle();
    chk("b2b_pc0", acc_at(0), 32'h400);
    chk("b2b_pc1", acc_at(1), 32'h404);

    // Redirect coincident with a response and a pop (latency 2).
    lat = 2;
    k = 0;
    while (!((mq.size() > 0) && (mq[0].due <= cyc) && (mf.size() > 0)) && k < 20) begin
      cycle();
      k++;
    end
    checks++;
    if (k >= 20) begin
      fails++;
      $display("FAIL wait_coincident: got %0d cycles required under 20", k);
    end
    redirect(32'h0000_0200);
    acc.delete();
    repeat (10) cycle();
    chk("coinc_pc0", acc_at(0), 32'h200);
    chk("coinc_pc1", acc_at(1), 32'h204);

    // PC wraps past the top of the address space.
    lat = 1;
    redirect(32'hFFFF_FFFC);
    acc.delete();
    repeat (6) cycle();
    chk("wrap_pc0", acc_at(0), 32'hFFFF_FFFC);
    chk("wrap_pc1", acc_at(1), 32'h0);

    // Mid-run reset with one request outstanding.
    lat = 3;
    wait_pend(1);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    acc.delete();
    cycle();
    chk("mid_rst_valid", 32'(vld_s), 32'd0);
    chk("mid_rst_addr", addr_s, 32'h0);
    chk("mid_rst_req", 32'(req_s), 32'd1);
    repeat (12) cycle();
    chk("mid_rst_pc0", acc_at(0), 32'h0);
    chk("mid_rst_pc1", acc_at(1), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
